// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage Y86 pipeline: stall/bubble strobes,
// memory-wait watchdog and terminal HALT. Define PIPE_CTRL_PERF_EN to add performance counters.
module pipe_ctrl #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    input  logic       dmem_ready,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_stall,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       W_bubble,
    output logic       halted,
    output logic       mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_bubble_cyc,
    output logic [31:0] perf_memwait_cyc
`endif
);

    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] R_NONE  = 4'hF;
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic                 timeout_nxt;

    logic mem_op, mem_busy, load_use, ret_pend, mispred, exc_m, exc_w;

    // Memory handshake: an M-stage access is outstanding while mem_op is high and completes
    // in the cycle dmem_ready is high; until then F, D and M hold and a nop drains into W.
    assign mem_op   = M_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    assign mem_busy = mem_op && !dmem_ready;
    assign load_use = (E_icode inside {4'h5, 4'hB}) && (E_dstM != R_NONE)
                      && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_Cnd;
    assign exc_m    = (m_stat != STAT_AOK);
    assign exc_w    = (W_stat != STAT_AOK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = 1'b0;
        case (state)
            RUN: begin
                if (exc_w) begin
                    state_nxt = HALT;
                end else if (mem_busy) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = TIMEOUT_W'(1);
                end
            end
            MEM_WAIT: begin
                // A faulting W-stage instruction wins over the watchdog in the same cycle.
                if (exc_w) begin
                    state_nxt = HALT;
                end else if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TIMEOUT_VAL) begin
                    state_nxt   = HALT;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + TIMEOUT_W'(1);
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_stall  = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else if (state == HALT) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            M_stall = 1'b1;
            W_stall = 1'b1;
            halted  = 1'b1;
        end else if (mem_busy) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            // load_use with a pending ret stalls D rather than bubbling it.
            F_stall  = load_use || ret_pend;
            D_stall  = load_use;
            D_bubble = mispred || (ret_pend && !load_use);
            E_bubble = mispred || load_use;
            M_bubble = exc_m || exc_w;
            W_stall  = exc_w;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cyc   <= '0;
            perf_bubble_cyc  <= '0;
            perf_memwait_cyc <= '0;
        end else if (state != HALT) begin
            if (F_stall)  perf_stall_cyc   <= perf_stall_cyc + 32'd1;
            if (E_bubble) perf_bubble_cyc  <= perf_bubble_cyc + 32'd1;
            if (mem_busy) perf_memwait_cyc <= perf_memwait_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step drives inputs, queues the expected strobe vector,
// and compares it against the DUT on the following falling edge.
module tb_pipe_ctrl;

    localparam int TW = 8;
    localparam int TO = 10;

    // Vector order: F_stall D_stall D_bubble E_bubble M_stall M_bubble W_stall W_bubble halted mem_timeout
    localparam logic [9:0] V_IDLE    = 10'b0000000000;
    localparam logic [9:0] V_RST     = 10'b0011010100;
    localparam logic [9:0] V_BUSY    = 10'b1100100100;
    localparam logic [9:0] V_HALT    = 10'b1100101010;
    localparam logic [9:0] V_HALT_TO = 10'b1100101011;
    localparam logic [9:0] V_LU      = 10'b1101000000;
    localparam logic [9:0] V_RET     = 10'b1010000000;
    localparam logic [9:0] V_MISP    = 10'b0011000000;
    localparam logic [9:0] V_MISPRET = 10'b1011000000;
    localparam logic [9:0] V_EXCW    = 10'b0000011000;
    localparam logic [9:0] V_EXCM    = 10'b0000010000;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic e_Cnd, dmem_ready;
    logic F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, W_bubble;
    logic halted, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_bubble_cyc, perf_memwait_cyc;
    logic [31:0] m_stall_cyc = 0, m_bubble_cyc = 0, m_memwait_cyc = 0;
`endif

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT_W(TW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .dmem_ready(dmem_ready),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble),
        .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc), .perf_bubble_cyc(perf_bubble_cyc),
        .perf_memwait_cyc(perf_memwait_cyc)
`endif
    );

    task automatic idle_inputs();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
        M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1;
        dmem_ready = 1'b1;
    endtask

    task automatic compare(input string t, input logic [31:0] obs, input logic [31:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", t, obs, e);
        end
    endtask

    // Queue the expectation for the current inputs, compare mid-cycle, then advance one edge.
    task automatic step(input string t, input logic [9:0] e);
        logic [9:0] obs, want;
        string      wt;
        logic       busy_in;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        obs  = {F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble,
                W_stall, W_bubble, halted, mem_timeout};
        want = exp_q.pop_front();
        wt   = tag_q.pop_front();
        compare(wt, 32'(obs), 32'(want));
        busy_in = (M_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) && !dmem_ready;
`ifdef PIPE_CTRL_PERF_EN
        compare({wt, "/perf_stall"}, perf_stall_cyc, m_stall_cyc);
        compare({wt, "/perf_bubble"}, perf_bubble_cyc, m_bubble_cyc);
        compare({wt, "/perf_memwait"}, perf_memwait_cyc, m_memwait_cyc);
        if (!rst) begin
            m_stall_cyc = 0; m_bubble_cyc = 0; m_memwait_cyc = 0;
        end else if (!want[1]) begin
            m_stall_cyc   = m_stall_cyc + 32'(want[9]);
            m_bubble_cyc  = m_bubble_cyc + 32'(want[6]);
            m_memwait_cyc = m_memwait_cyc + 32'(busy_in);
        end
`else
        if (busy_in && rst && want[2] !== 1'b1) $display("note: %s busy with no W bubble expected", wt);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        step("reset", V_RST);
        rst = 1'b1;
        step("idle", V_IDLE);

        // Load-use on d_srcB, then the bubble has left E.
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; D_icode = 4'h6;
        step("load_use", V_LU);
        E_icode = 4'h1; E_dstM = 4'hF;
        step("load_use_after", V_IDLE);
        E_icode = 4'h5; E_dstM = 4'hF; d_srcB = 4'hF;
        step("load_use_dstm_none", V_IDLE);
        idle_inputs();

        // ret walking D -> E -> M.
        D_icode = 4'h9;
        step("ret_d", V_RET);
        D_icode = 4'h1; E_icode = 4'h9;
        step("ret_e", V_RET);
        E_icode = 4'h1; M_icode = 4'h9;
        step("ret_m", V_RET);
        M_icode = 4'h1;
        step("ret_gone", V_IDLE);

        // ret in D while a load in E feeds %rsp.
        D_icode = 4'h9; d_srcA = 4'h4; d_srcB = 4'h4; E_icode = 4'hB; E_dstM = 4'h4;
        step("ret_load_use", V_LU);
        idle_inputs();

        E_icode = 4'h7; e_Cnd = 1'b0;
        step("mispred", V_MISP);
        D_icode = 4'h9;
        step("mispred_ret", V_MISPRET);
        D_icode = 4'h1; e_Cnd = 1'b1;
        step("jxx_taken", V_IDLE);
        idle_inputs();

        m_stat = 4'h3;
        step("exc_m", V_EXCM);
        m_stat = 4'h1;

        // Access completing in its first cycle adds no wait.
        M_icode = 4'h5;
        step("mem_zero_wait", V_IDLE);
        M_icode = 4'h1;
        step("mem_zero_after", V_IDLE);

        // Four wait cycles, then completion; hazards are masked while waiting.
        M_icode = 4'h5; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; m_stat = 4'h4;
            end
            step($sformatf("mem_wait_%0d", i), V_BUSY);
            E_icode = 4'h1; E_dstM = 4'hF; d_srcA = 4'hF; m_stat = 4'h1;
        end
        dmem_ready = 1'b1;
        step("mem_done", V_IDLE);
        M_icode = 4'h1;
        step("mem_run", V_IDLE);

        // Reset in the middle of a wait, then a full watchdog expiry from a clean start.
        M_icode = 4'h5; dmem_ready = 1'b0;
        step("rst_wait_0", V_BUSY);
        step("rst_wait_1", V_BUSY);
        rst = 1'b0;
        step("rst_in_wait_0", V_RST);
        step("rst_in_wait_1", V_RST);
        rst = 1'b1;
        for (int i = 0; i <= TO; i++) begin
            if (i == 5) begin
                E_icode = 4'h7; e_Cnd = 1'b0;
            end
            step($sformatf("to_wait_%0d", i), V_BUSY);
            E_icode = 4'h1; e_Cnd = 1'b1;
        end
        M_icode = 4'h1; dmem_ready = 1'b1;
        step("to_pulse", V_HALT_TO);
        step("to_halt_0", V_HALT);
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        step("to_halt_1", V_HALT);
        idle_inputs();
        rst = 1'b0;
        step("to_reset", V_RST);
        rst = 1'b1;
        step("to_run", V_IDLE);

        // W-stage fault freezes the pipeline until reset.
        W_stat = 4'h2;
        step("exc_w", V_EXCW);
        W_stat = 4'h1;
        for (int i = 0; i < 3; i++) step($sformatf("exc_halt_%0d", i), V_HALT);
        rst = 1'b0;
        step("exc_reset", V_RST);
        rst = 1'b1;
        step("exc_run", V_IDLE);

        // Fault while memory is busy: busy strobes win this cycle, HALT follows.
        M_icode = 4'h5; dmem_ready = 1'b0; W_stat = 4'h3;
        step("exc_w_busy", V_BUSY);
        idle_inputs();
        step("exc_w_busy_halt", V_HALT);
        rst = 1'b0;
        step("final_reset", V_RST);
        rst = 1'b1;
        step("final_run", V_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
